pipelined_adder_array: RTL and testbench

- Parametrised, multi-channel, two-stage pipelined adder/subtractor/accumulator with valid/ready handshake on both sides.
- Successor to the single combinational `c = a + b` datapath. Adds channel count, width, operation select, optional saturation, per-channel accumulators and back-pressure.
- Sits between a producer stream and a consumer stream. All sequential logic is in `always_ff` with nonblocking assignments; all combinational logic is in `always_comb`.
- No procedural continuous assignment anywhere.

---
 rtl/pipelined_adder_array_pkg.sv | 32 +++
 rtl/pipelined_adder_array_if.sv | 31 +++
 rtl/adder_lane.sv | 52 +++++
 rtl/pipelined_adder_array.sv | 90 +++++++++
 tb/tb_pipelined_adder_array.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_adder_array_pkg.sv
// Shared types and helpers for the pipelined adder array.
// Contents: op_e operation encoding, lane-width limit, sat_trunc result shaping.
package pipelined_adder_array_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_ACC = 2'd2,
    OP_CLR = 2'd3
  } op_e;

  // Widest lane the helper can shape; callers zero-extend their WIDTH+1 result.
  localparam int unsigned MAX_W = 64;
  localparam int unsigned RAW_W = MAX_W + 1;

  // Reduce a width+1 raw lane result to width bits: clamp when saturating, else wrap.
  // Bit 'width' of raw is the carry (add/acc) or borrow (sub).
  function automatic logic [MAX_W-1:0] sat_trunc(input logic [RAW_W-1:0] raw,
                                                 input int unsigned      width,
                                                 input logic             is_sub,
                                                 input logic             saturate);
    logic [MAX_W-1:0] mask;
    logic             ovf;
    mask = ~({MAX_W{1'b1}} << width);
    ovf  = |(raw & (RAW_W'(1) << width));
    if (saturate && ovf) begin
      return is_sub ? '0 : mask;
    end
    return raw[MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/pipelined_adder_array_if.sv
// Producer/consumer stream bundle for the pipelined adder array.
// slave : DUT side (takes in_*, out_ready; drives in_ready, out_*).
// master: stream source/sink side.
interface pipelined_adder_array_if
  import pipelined_adder_array_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_CH = 4
);

  logic                    in_valid;
  logic                    in_ready;
  op_e                     in_op;
  logic [NUM_CH*WIDTH-1:0] in_a;
  logic [NUM_CH*WIDTH-1:0] in_b;
  logic                    out_valid;
  logic                    out_ready;
  logic [NUM_CH*WIDTH-1:0] out_sum;
  logic [NUM_CH-1:0]       out_ovf;

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

endinterface

// File: rtl/adder_lane.sv
// One lane: S1 arithmetic at WIDTH+1 bits plus the lane accumulator.
// Ports: clk, rst_n (sync, active-low), load_i (transaction accepted),
//        op_i, a_i, b_i (lane operands), raw_o (registered S1 raw result).
module adder_lane
  import pipelined_adder_array_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  op_e              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   raw_o
);

  logic [WIDTH:0]   raw_d, raw_q;
  logic [WIDTH-1:0] acc_d, acc_q;

  // Raw result; the accumulator takes its final shaped value in the accept
  // cycle so back-to-back ACC chains without a bubble.
  always_comb begin
    raw_d = '0;
    acc_d = acc_q;
    case (op_i)
      OP_ADD: raw_d = {1'b0, a_i} + {1'b0, b_i};
      OP_SUB: raw_d = {1'b0, a_i} - {1'b0, b_i};
      OP_ACC: begin
        raw_d = {1'b0, acc_q} + {1'b0, a_i};
        acc_d = WIDTH'(sat_trunc(RAW_W'(raw_d), WIDTH, 1'b0, SATURATE != 0));
      end
      OP_CLR: acc_d = '0;
      default: ;
    endcase
  end

  // S1 register and accumulator only move on an accepted transaction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      raw_q <= '0;
      acc_q <= '0;
    end else if (load_i) begin
      raw_q <= raw_d;
      acc_q <= acc_d;
    end
  end

  always_comb raw_o = raw_q;

endmodule

// File: rtl/pipelined_adder_array.sv
// Multi-lane two-stage add/sub/accumulate pipeline with valid/ready on both sides.
// Ports: clk, rst_n (sync, active-low), bus (slave view of the stream bundle).
// S1 lives in the lanes (raw WIDTH+1 results) plus the op here; S2 shapes and
// holds out_sum/out_ovf until the consumer takes them.
module pipelined_adder_array
  import pipelined_adder_array_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned SATURATE = 0
) (
  input logic                     clk,
  input logic                     rst_n,
  pipelined_adder_array_if.slave  bus
);

  logic                               s2_adv;
  logic                               in_ready_c;
  logic                               accept;
  logic                               s1_valid_d, s1_valid_q;
  op_e                                s1_op_q;
  logic                               out_valid_q;
  logic [NUM_CH-1:0][WIDTH:0]         raw;
  logic [NUM_CH-1:0][WIDTH-1:0]       sum_d, sum_q;
  logic [NUM_CH-1:0]                  ovf_d, ovf_q;

  // Handshake: S1 may refill whenever it is empty or draining into S2.
  always_comb begin
    s2_adv     = !out_valid_q || bus.out_ready;
    in_ready_c = rst_n && (!s1_valid_q || s2_adv);
    accept     = bus.in_valid && in_ready_c;
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_valid_d = 1'b1;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    adder_lane #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (accept),
      .op_i   (bus.in_op),
      .a_i    (bus.in_a[k*WIDTH +: WIDTH]),
      .b_i    (bus.in_b[k*WIDTH +: WIDTH]),
      .raw_o  (raw[k])
    );

    // S2 shaping; the top raw bit is the carry/borrow flag in every op.
    always_comb begin
      sum_d[k] = WIDTH'(sat_trunc(RAW_W'(raw[k]), WIDTH, s1_op_q == OP_SUB, SATURATE != 0));
      ovf_d[k] = raw[k][WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_op_q <= bus.in_op;
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          sum_q <= sum_d;
          ovf_q <= ovf_d;
        end
      end
    end
  end

  always_comb begin
    bus.in_ready  = in_ready_c;
    bus.out_valid = out_valid_q;
    bus.out_sum   = sum_q;
    bus.out_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_pipelined_adder_array.sv
// Scoreboard bench: a wrapping and a saturating instance share one stimulus
// stream; each has its own expected-result queue and monitor.
module tb_pipelined_adder_array;
  import pipelined_adder_array_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = W * N;

  typedef struct packed {
    logic [DW-1:0] sum;
    logic [N-1:0]  ovf;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  op_e           in_op;
  logic [DW-1:0] in_a, in_b;
  logic          out_ready;

  int   checks = 0;
  int   errors = 0;
  int   last_wait;
  exp_t q0[$];
  exp_t q1[$];
  exp_t m0, m1;

  pipelined_adder_array_if #(.WIDTH(W), .NUM_CH(N)) bus0 ();
  pipelined_adder_array_if #(.WIDTH(W), .NUM_CH(N)) bus1 ();

  assign bus0.in_valid  = in_valid;
  assign bus0.in_op     = in_op;
  assign bus0.in_a      = in_a;
  assign bus0.in_b      = in_b;
  assign bus0.out_ready = out_ready;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_op     = in_op;
  assign bus1.in_a      = in_a;
  assign bus1.in_b      = in_b;
  assign bus1.out_ready = out_ready;

  pipelined_adder_array #(.WIDTH(W), .NUM_CH(N), .SATURATE(0)) u_wrap (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  pipelined_adder_array #(.WIDTH(W), .NUM_CH(N), .SATURATE(1)) u_sat (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, required finish before 100us");
    $fatal(1);
  end

  function automatic exp_t mk(input logic [DW-1:0] s, input logic [N-1:0] o);
    exp_t e;
    e.sum = s;
    e.ovf = o;
    return e;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Present one transaction until accepted; expectations are queued at accept.
  task automatic send(input op_e op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic push, input exp_t e0, input exp_t e1);
    logic ok;
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    last_wait = 0;
    ok        = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus0.in_ready) begin
        ok = 1'b1;
        break;
      end
      last_wait++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, required acceptance");
    end else if (push) begin
      q0.push_back(e0);
      q1.push_back(e1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_ready && bus0.out_valid) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL wrap_extra: got sum=%h ovf=%b, required no output", bus0.out_sum, bus0.out_ovf);
      end else begin
        m0 = q0.pop_front();
        if (bus0.out_sum !== m0.sum || bus0.out_ovf !== m0.ovf) begin
          errors++;
          $display("FAIL wrap_result: got sum=%h ovf=%b, required sum=%h ovf=%b",
                   bus0.out_sum, bus0.out_ovf, m0.sum, m0.ovf);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_ready && bus1.out_valid) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL sat_extra: got sum=%h ovf=%b, required no output", bus1.out_sum, bus1.out_ovf);
      end else begin
        m1 = q1.pop_front();
        if (bus1.out_sum !== m1.sum || bus1.out_ovf !== m1.ovf) begin
          errors++;
          $display("FAIL sat_result: got sum=%h ovf=%b, required sum=%h ovf=%b",
                   bus1.out_sum, bus1.out_ovf, m1.sum, m1.ovf);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] held;
    logic          have_held;
    logic          took;
    int            idx;
    logic [DW-1:0] sa [3];
    logic [DW-1:0] sb [3];
    exp_t          se [3];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = OP_ADD;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("in_ready_in_reset", DW'(bus0.in_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", DW'(bus0.out_valid), 0);
    chk("rst_out_sum", bus0.out_sum, 0);
    chk("rst_out_ovf", DW'(bus0.out_ovf), 0);
    chk("rst_in_ready", DW'(bus0.in_ready), 1);
    @(posedge clk);
    #1;

    // ADD with carries; two-cycle latency
    send(OP_ADD, 32'hFF00F010, 32'h01002020, 1'b1,
         mk(32'h00001030, 4'b1010), mk(32'hFF00FF30, 4'b1010));
    @(negedge clk);
    chk("latency_cycle1", DW'(bus0.out_valid), 0);
    @(negedge clk);
    chk("latency_cycle2", DW'(bus0.out_valid), 1);
    @(posedge clk);
    #1;

    // SUB with borrows, then mixed ADD
    send(OP_SUB, 32'h80051000, 32'h7F091001, 1'b1,
         mk(32'h01FC00FF, 4'b0101), mk(32'h01000000, 4'b0101));
    send(OP_ADD, 32'h7F7F0102, 32'h80810203, 1'b1,
         mk(32'hFF000305, 4'b0100), mk(32'hFFFF0305, 4'b0100));

    // CLR then chained ACC; fourth wraps (or clamps)
    send(OP_CLR, 32'h12345678, 32'h9ABCDEF0, 1'b1, mk(0, 0), mk(0, 0));
    send(OP_ACC, 32'h40404040, 32'hFFFFFFFF, 1'b1, mk(32'h40404040, 0), mk(32'h40404040, 0));
    send(OP_ACC, 32'h40404040, 32'h0, 1'b1, mk(32'h80808080, 0), mk(32'h80808080, 0));
    chk("acc_no_bubble2", DW'(last_wait), 0);
    send(OP_ACC, 32'h40404040, 32'h0, 1'b1, mk(32'hC0C0C0C0, 0), mk(32'hC0C0C0C0, 0));
    chk("acc_no_bubble3", DW'(last_wait), 0);
    send(OP_ACC, 32'h40404040, 32'h0, 1'b1, mk(32'h00000000, 4'hF), mk(32'hFFFFFFFF, 4'hF));
    idle(4);

    // Back-pressure: five stalled cycles with continuous in_valid
    sa[0] = 32'h01020304; sb[0] = 32'h10101010; se[0] = mk(32'h11121314, 0);
    sa[1] = 32'hAAAAAAAA; sb[1] = 32'h55555555; se[1] = mk(32'hFFFFFFFF, 0);
    sa[2] = 32'h80808080; sb[2] = 32'h80808080; se[2] = mk(32'h00000000, 4'hF);
    out_ready = 1'b0;
    idx       = 0;
    have_held = 1'b0;
    held      = '0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_op    = OP_ADD;
      in_a     = sa[idx];
      in_b     = sb[idx];
      @(negedge clk);
      took = bus0.in_ready;
      if (took) begin
        q0.push_back(se[idx]);
        q1.push_back(idx == 2 ? mk(32'hFFFFFFFF, 4'hF) : se[idx]);
      end
      if (bus0.out_valid) begin
        if (!have_held) begin
          held      = bus0.out_sum;
          have_held = 1'b1;
        end else begin
          chk("stall_hold_sum", bus0.out_sum, held);
        end
      end
      @(posedge clk);
      #1;
      if (took) idx++;
    end
    in_valid = 1'b0;
    chk("stall_accepts", DW'(idx), 2);
    chk("stall_in_ready", DW'(bus0.in_ready), 0);
    chk("stall_out_valid", DW'(bus0.out_valid), 1);
    out_ready = 1'b1;
    send(OP_ADD, sa[2], sb[2], 1'b1, se[2], mk(32'hFFFFFFFF, 4'hF));
    idle(4);

    // Mid-flight reset with acc = 0x55
    send(OP_CLR, 32'h0, 32'h0, 1'b1, mk(0, 0), mk(0, 0));
    send(OP_ACC, 32'h55555555, 32'h0, 1'b1, mk(32'h55555555, 0), mk(32'h55555555, 0));
    idle(4);
    out_ready = 1'b0;
    send(OP_ACC, 32'h0, 32'h0, 1'b0, mk(0, 0), mk(0, 0));
    send(OP_ACC, 32'h0, 32'h0, 1'b0, mk(0, 0), mk(0, 0));
    chk("inflight_out_valid", DW'(bus0.out_valid), 1);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_op    = OP_ACC;
    in_a     = 32'h10101010;
    @(negedge clk);
    chk("reset_blocks_ready", DW'(bus0.in_ready), 0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("reset_drops_out_valid", DW'(bus0.out_valid), 0);
    chk("reset_drops_sat_valid", DW'(bus1.out_valid), 0);
    out_ready = 1'b1;
    send(OP_ACC, 32'h01010101, 32'h0, 1'b1, mk(32'h01010101, 0), mk(32'h01010101, 0));
    idle(4);

    // Refused ACC must not touch the accumulator
    out_ready = 1'b0;
    send(OP_ADD, 32'h01010101, 32'h01010101, 1'b1, mk(32'h02020202, 0), mk(32'h02020202, 0));
    send(OP_ADD, 32'h10101010, 32'h10101010, 1'b1, mk(32'h20202020, 0), mk(32'h20202020, 0));
    in_valid = 1'b1;
    in_op    = OP_ACC;
    in_a     = 32'h10101010;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("refused_acc_ready", DW'(bus0.in_ready), 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle(4);
    send(OP_ACC, 32'h0, 32'h0, 1'b1, mk(32'h01010101, 0), mk(32'h01010101, 0));
    idle(5);

    chk("wrap_queue_drained", DW'(q0.size()), 0);
    chk("sat_queue_drained", DW'(q1.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
